// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if: payload handshake, abort and serial frame outputs of seq_frame_tx
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              tx_out;
  logic              tx_active;
  logic              frame_done;
  modport master (
    output in_data, in_valid, abort,
    input  in_ready, tx_out, tx_active, frame_done
  );
  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, tx_out, tx_active, frame_done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter sending preamble, payload MSB first, then idle-zero gap
module seq_frame_tx #(
  parameter int                  DATA_W   = 8,
  parameter int                  SYNC_LEN = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 5'b11010,
  parameter int                  GAP_CYC  = 2
) (
  input logic          clk,
  input logic          rstn,
  seq_frame_tx_if.slave bus
);
  localparam int ML = SYNC_LEN > DATA_W ? SYNC_LEN : DATA_W;
  localparam int BW = ML > 1 ? $clog2(ML) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;
  state_t              state, state_n;
  logic [DATA_W-1:0]   sh, sh_n;
  logic [SYNC_LEN-1:0] pat, pat_n;
  logic [BW-1:0]       cnt, cnt_n;
  logic [GW-1:0]       gcnt, gcnt_n;
  logic                tx, tx_n, act, act_n, done, done_n;
  assign bus.in_ready   = state == IDLE;
  assign bus.tx_out     = tx;
  assign bus.tx_active  = act;
  assign bus.frame_done = done;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sh    <= '0;
      pat   <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      tx    <= 1'b0;
      act   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      pat   <= pat_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
      tx    <= tx_n;
      act   <= act_n;
      done  <= done_n;
    end
  end
  // cnt holds how many bits of the current section remain after the one on tx_out
  always_comb begin
    state_n = state;
    sh_n    = sh;
    pat_n   = pat;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    tx_n    = tx;
    act_n   = act;
    done_n  = 1'b0;
    if ((state == SYNC || state == DATA) && bus.abort) begin
      state_n = GAP;
      tx_n    = 1'b0;
      act_n   = 1'b0;
      gcnt_n  = GW'(GAP_CYC - 1);
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state_n = SYNC;
          sh_n    = bus.in_data;
          pat_n   = SYNC_PAT << 1;
          tx_n    = SYNC_PAT[SYNC_LEN-1];
          act_n   = 1'b1;
          cnt_n   = BW'(SYNC_LEN - 1);
        end
        SYNC: if (cnt == '0) begin
          state_n = DATA;
          tx_n    = sh[DATA_W-1];
          sh_n    = sh << 1;
          cnt_n   = BW'(DATA_W - 1);
        end else begin
          tx_n  = pat[SYNC_LEN-1];
          pat_n = pat << 1;
          cnt_n = cnt - 1'b1;
        end
        DATA: if (cnt == '0) begin
          state_n = GAP;
          tx_n    = 1'b0;
          act_n   = 1'b0;
          done_n  = 1'b1;
          gcnt_n  = GW'(GAP_CYC - 1);
        end else begin
          tx_n  = sh[DATA_W-1];
          sh_n  = sh << 1;
          cnt_n = cnt - 1'b1;
        end
        GAP: if (gcnt == '0) state_n = IDLE;
             else gcnt_n = gcnt - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed and random frames checked against a queue-of-cycles frame model
module tb_seq_frame_tx;
  localparam int         DW = 8;
  localparam int         SL = 5;
  localparam int         GC = 2;
  localparam logic [4:0] SP = 5'b11010;
  typedef struct packed {logic o; logic a; logic f;} ent_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  seq_frame_tx_if #(.DATA_W(DW)) bus ();
  seq_frame_tx_if #(.DATA_W(1))  bus1 ();
  seq_frame_tx #(.DATA_W(DW), .SYNC_LEN(SL), .SYNC_PAT(SP), .GAP_CYC(GC)) dut (
    .clk(clk), .rstn(rstn), .bus(bus.slave));
  seq_frame_tx #(.DATA_W(1), .SYNC_LEN(1), .SYNC_PAT(1'b1), .GAP_CYC(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1.slave));
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          t0;
  logic        acc_now;
  logic        busy_m = 1'b0;
  ent_t        cur = '0;
  ent_t        q[$];
  logic [4:0]  sp = SP;
  logic [31:0] bits = '0;
  logic        d1, d1n;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = SL - 1; i >= 0; i--) q.push_back(ent_t'({sp[i], 2'b10}));
    for (int i = DW - 1; i >= 0; i--) q.push_back(ent_t'({d[i], 2'b10}));
    q.push_back(ent_t'(3'b001));
    for (int i = 1; i < GC; i++) q.push_back(ent_t'(3'b000));
  endtask
  task automatic tick();
    acc_now = bus.in_valid && !busy_m;
    if (acc_now) push_frame(bus.in_data);
    else if (bus.abort && cur.a) begin
      q.delete();
      repeat (GC) q.push_back(ent_t'(3'b000));
    end
    @(posedge clk);
    cyc++;
    if (acc_now) acc_cyc = cyc;
    if (q.size() > 0) begin
      cur = q.pop_front();
      busy_m = 1'b1;
    end else begin
      cur = '0;
      busy_m = 1'b0;
    end
    #1;
    bits = {bits[30:0], bus.tx_out};
    chk("tx_out", 32'(bus.tx_out), 32'(cur.o));
    chk("tx_active", 32'(bus.tx_active), 32'(cur.a));
    chk("frame_done", 32'(bus.frame_done), 32'(cur.f));
    chk("in_ready", 32'(bus.in_ready), 32'(!busy_m));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.abort = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data = '0;
    bus1.abort = 1'b0;
    // reset state
    tick();
    tick();
    #2 rstn = 1'b1;
    tick();
    // frame of 8'hA5
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bits = '0;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (12) tick();
    chk("frame_a5_bits", bits & 32'h1FFF, 32'h1AA5);
    repeat (4) tick();
    // back to back, second word held off while busy
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    tick();
    t0 = acc_cyc;
    bus.in_data = 8'h00;
    for (int i = 0; i < 40 && acc_cyc == t0; i++) tick();
    chk("b2b_period", 32'(acc_cyc - t0), 32'd16);
    bus.in_valid = 1'b0;
    repeat (16) tick();
    // valid pulses while busy are ignored; held word taken on first idle cycle
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    tick();
    t0 = acc_cyc;
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = (i % 4 == 1);
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'hC3;
    for (int i = 0; i < 40 && acc_cyc == t0; i++) tick();
    chk("held_accept", 32'(acc_cyc - t0), 32'd16);
    bus.in_valid = 1'b0;
    repeat (16) tick();
    // abort during the third data bit
    bus.in_valid = 1'b1;
    bus.in_data = 8'h96;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_drop", 32'({bus.tx_out, bus.tx_active, bus.frame_done}), 32'd0);
    repeat (4) tick();
    // asynchronous reset mid-data
    bus.in_valid = 1'b1;
    bus.in_data = 8'hE7;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    #3 rstn = 1'b0;
    #1;
    chk("rst_tx_out", 32'(bus.tx_out), 32'd0);
    chk("rst_tx_active", 32'(bus.tx_active), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    cur = '0;
    busy_m = 1'b0;
    #2 rstn = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    bits = '0;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("post_rst_sync", bits & 32'h1F, 32'h1A);
    repeat (12) tick();
    // random traffic with aborts and in_data churn
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 2) == 0);
      bus.in_data = 8'($urandom);
      bus.abort = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    repeat (20) tick();
    // minimal configuration: frame 1,d then one gap cycle, period 4
    bus1.in_valid = 1'b1;
    d1n = 1'($urandom);
    for (int f = 0; f < 6; f++) begin
      d1 = d1n;
      d1n = 1'($urandom);
      bus1.in_data = d1;
      @(posedge clk);
      #1;
      bus1.in_data = ~d1;
      chk("p1_sync", 32'({bus1.tx_out, bus1.tx_active, bus1.frame_done, bus1.in_ready}), 32'b1100);
      @(posedge clk);
      #1;
      chk("p1_data", 32'({bus1.tx_out, bus1.tx_active, bus1.frame_done, bus1.in_ready}), 32'({d1, 3'b100}));
      @(posedge clk);
      #1;
      chk("p1_gap", 32'({bus1.tx_out, bus1.tx_active, bus1.frame_done, bus1.in_ready}), 32'b0010);
      @(posedge clk);
      #1;
      chk("p1_idle", 32'({bus1.tx_out, bus1.tx_active, bus1.frame_done, bus1.in_ready}), 32'b0001);
    end
    bus1.in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
